// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage that holds the PC, issues one imem word request at a
// time and hands {inst, inst_pc} to decode over a valid/ready handshake.
// Optional build macro IFU_MISALIGN_CHECK_EN: misaligned redirects enter a sticky FAULT
// state; without it the low two bits of a redirect target are cleared when loaded.
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt_req,
    output logic            o_fetch_fault
);

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_STOP, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_state_n;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_n;
    logic            r_kill;
    logic            w_kill_n;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            w_latch;
    logic [XLEN-1:0] w_redir_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign    = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    assign w_redir_pc    = i_redirect_pc;
    assign o_fetch_fault = (r_state == S_FAULT);
`else
    assign w_redir_pc    = i_redirect_pc & ~XLEN'(3);
    assign o_fetch_fault = 1'b0;
`endif

    assign o_imem_req_valid = (r_state == S_REQ);
    assign o_imem_req_addr  = r_pc;
    assign o_inst_valid     = (r_state == S_HOLD);
    assign o_inst           = r_inst;
    assign o_inst_pc        = r_inst_pc;

    // Next-state, next-PC and kill-flag selection; a redirect outranks every other PC update.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_kill_n  = r_kill;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: w_state_n = S_REQ;
            S_REQ: begin
                if (i_redirect_valid) begin
                    w_pc_n    = w_redir_pc;
                    w_kill_n  = i_imem_req_ready;
                    w_state_n = i_imem_req_ready ? S_WAIT : S_REQ;
                end else if (i_imem_req_ready) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    w_pc_n    = w_redir_pc;
                    w_kill_n  = !i_imem_rsp_valid;
                    w_state_n = i_imem_rsp_valid ? S_REQ : S_WAIT;
                end else if (i_imem_rsp_valid) begin
                    w_kill_n  = 1'b0;
                    w_latch   = !r_kill;
                    w_state_n = r_kill ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid) begin
                    w_pc_n    = w_redir_pc;
                    w_state_n = S_REQ;
                end else if (i_inst_ready) begin
                    w_pc_n    = r_pc + XLEN'(4);
                    w_state_n = i_halt_req ? S_STOP : S_REQ;
                end
            end
            default: w_state_n = r_state;
        endcase
`ifdef IFU_MISALIGN_CHECK_EN
        if (w_misalign && (r_state == S_REQ || r_state == S_WAIT || r_state == S_HOLD)) begin
            w_state_n = S_FAULT;
            w_latch   = 1'b0;
        end
`endif
    end

    // State, PC, kill flag and the instruction/PC pair presented to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_kill    <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_kill  <= w_kill_n;
            if (w_latch) begin
                r_inst    <= i_imem_rsp_data;
                r_inst_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed-vector bench for ifu_fetch with a one-outstanding imem model.
module tb_ifu_fetch;
    logic        clk;
    logic        rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        i_halt_req;
    logic        o_fetch_fault;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_addr = '0;
    logic [31:0] ovr_data = '0;
    logic [31:0] req_q[$];
    int          reqc_q[$];
    logic [31:0] pres_pc_q[$];
    logic [31:0] pres_inst_q[$];
    int          rb;
    int          pb;

    ifu_fetch dut (
        .clk(clk),
        .rst(rst),
        .o_imem_req_valid(o_imem_req_valid),
        .i_imem_req_ready(i_imem_req_ready),
        .o_imem_req_addr(o_imem_req_addr),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data(i_imem_rsp_data),
        .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready),
        .o_inst(o_inst),
        .o_inst_pc(o_inst_pc),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc(i_redirect_pc),
        .i_halt_req(i_halt_req),
        .o_fetch_fault(o_fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory model (one outstanding request, response lat cycles after acceptance) and logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            cnt              <= 0;
            i_imem_rsp_valid <= 1'b0;
        end else begin
            if (o_imem_req_valid && i_imem_req_ready) begin
                req_q.push_back(o_imem_req_addr);
                reqc_q.push_back(cyc);
                pend             <= o_imem_req_addr;
                cnt              <= lat;
                i_imem_rsp_valid <= (lat == 1);
                i_imem_rsp_data  <= (ovr_en && o_imem_req_addr == ovr_addr) ? ovr_data : dflt(o_imem_req_addr);
            end else begin
                cnt              <= (cnt > 0) ? cnt - 1 : 0;
                i_imem_rsp_valid <= (cnt == 2);
                i_imem_rsp_data  <= (ovr_en && pend == ovr_addr) ? ovr_data : dflt(pend);
            end
            if (o_inst_valid && i_inst_ready) begin
                pres_pc_q.push_back(o_inst_pc);
                pres_inst_q.push_back(o_inst);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_halt_req       = 1'b0;
        repeat (3) @(negedge clk);
        rb  = req_q.size();
        pb  = pres_pc_q.size();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < 200 && req_q.size() < rb + n; i++) @(negedge clk);
        chk("req_count", req_q.size() - rb, n);
    endtask

    task automatic wait_iv();
        for (int i = 0; i < 200 && !o_inst_valid; i++) @(negedge clk);
        chk("inst_valid_up", o_inst_valid, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = pc;
        @(negedge clk);
        i_redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        i_imem_req_ready = 1'b1;
        i_inst_ready     = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_halt_req       = 1'b0;

        // reset values, then the IDLE cycle right after release
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", o_imem_req_valid, 1'b0);
        chk("rst_inst_valid", o_inst_valid, 1'b0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_inst_pc", o_inst_pc, 32'h0);
        chk("rst_fault", o_fetch_fault, 1'b0);
        chk("rst_addr", o_imem_req_addr, 32'h8000_0000);

        // back-to-back fetch, zero-wait memory
        do_reset();
        chk("idle_req_valid", o_imem_req_valid, 1'b0);
        wait_req(3);
        chk("tp_addr0", req_q[rb], 32'h8000_0000);
        chk("tp_addr1", req_q[rb+1], 32'h8000_0004);
        chk("tp_addr2", req_q[rb+2], 32'h8000_0008);
        chk("tp_gap01", reqc_q[rb+1] - reqc_q[rb], 3);
        chk("tp_gap12", reqc_q[rb+2] - reqc_q[rb+1], 3);
        chk("tp_pc0", pres_pc_q[pb], 32'h8000_0000);
        chk("tp_pc1", pres_pc_q[pb+1], 32'h8000_0004);
        chk("tp_inst0", pres_inst_q[pb], dflt(32'h8000_0000));
        chk("tp_inst1", pres_inst_q[pb+1], dflt(32'h8000_0004));

        // decode stall for 5 cycles in HOLD
        ovr_en = 1'b1; ovr_addr = 32'h8000_0000; ovr_data = 32'h0050_0093;
        i_inst_ready = 1'b0;
        do_reset();
        wait_iv();
        for (int i = 0; i < 5; i++) begin
            chk("stall_inst", o_inst, 32'h0050_0093);
            chk("stall_pc", o_inst_pc, 32'h8000_0000);
            chk("stall_noreq", o_imem_req_valid, 1'b0);
            chk("stall_valid", o_inst_valid, 1'b1);
            @(negedge clk);
        end
        chk("stall_reqs", req_q.size() - rb, 1);
        i_inst_ready = 1'b1;
        wait_req(2);
        chk("stall_next", req_q[rb+1], 32'h8000_0004);
        chk("stall_pres", pres_pc_q[pb], 32'h8000_0000);

        // redirect while a response is outstanding; stale data must never reach decode
        ovr_data = 32'hDEAD_BEEF;
        lat = 3;
        do_reset();
        wait_req(1);
        redirect(32'h8000_0100);
        wait_req(2);
        chk("rw_next", req_q[rb+1], 32'h8000_0100);
        for (int i = 0; i < 200 && pres_pc_q.size() == pb; i++) @(negedge clk);
        chk("rw_pres_pc", pres_pc_q[pb], 32'h8000_0100);
        chk("rw_pres_inst", pres_inst_q[pb], dflt(32'h8000_0100));
        ovr_en = 1'b0;
        lat = 1;

        // redirect coinciding with the decode handshake in HOLD
        i_inst_ready = 1'b0;
        do_reset();
        wait_iv();
        i_inst_ready = 1'b1;
        redirect(32'h8000_0040);
        chk("rh_valid_low", o_inst_valid, 1'b0);
        chk("rh_req", o_imem_req_valid, 1'b1);
        chk("rh_addr", o_imem_req_addr, 32'h8000_0040);
        wait_req(2);
        chk("rh_next", req_q[rb+1], 32'h8000_0040);

        // halt on handshake at 0x8000000C, then restart through reset
        do_reset();
        for (int i = 0; i < 200 && !(o_inst_valid && o_inst_pc == 32'h8000_000C); i++) @(negedge clk);
        chk("halt_pc", o_inst_pc, 32'h8000_000C);
        i_halt_req = 1'b1;
        @(negedge clk);
        i_halt_req = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_imem_req_valid || o_inst_valid) n++;
            @(negedge clk);
        end
        chk("halt_quiet", n, 0);
        chk("halt_reqs", req_q.size() - rb, 4);
        do_reset();
        wait_req(1);
        chk("halt_restart", req_q[rb], 32'h8000_0000);

        // PC wraps from the top of the address space
        i_imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10 && !o_imem_req_valid; i++) @(negedge clk);
        redirect(32'hFFFF_FFFC);
        i_imem_req_ready = 1'b1;
        wait_req(2);
        chk("wrap_top", req_q[rb], 32'hFFFF_FFFC);
        chk("wrap_zero", req_q[rb+1], 32'h0);

        // misaligned redirect target
        i_imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10 && !o_imem_req_valid; i++) @(negedge clk);
        redirect(32'h8000_0102);
`ifdef IFU_MISALIGN_CHECK_EN
        i_imem_req_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_imem_req_valid || o_inst_valid || !o_fetch_fault) n++;
            @(negedge clk);
        end
        chk("mis_fault_sticky", n, 0);
        chk("mis_noreq", req_q.size() - rb, 0);
`else
        chk("mis_fault", o_fetch_fault, 1'b0);
        chk("mis_addr", o_imem_req_addr, 32'h8000_0100);
        i_imem_req_ready = 1'b1;
        wait_req(1);
        chk("mis_req", req_q[rb], 32'h8000_0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
